// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin grant arbiter.
package arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;
    localparam int ARB_N        = 8;
    localparam int ARB_IDXW     = 3;
    localparam int ARB_MAX_HOLD = 16;
    localparam int ARB_HCW      = 5;
endpackage

// File: rtl/idx_to_onehot.sv
// idx_to_onehot: expands an index plus enable into a one-hot vector (all zeros when disabled).
module idx_to_onehot #(
    parameter int IDXW = 3
) (
    input  logic [IDXW-1:0]    idx,
    input  logic               en,
    output logic [2**IDXW-1:0] onehot
);
    assign onehot = {{(2**IDXW-1){1'b0}}, en} << idx;
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with registered one-hot grant, release/timeout and a dead cycle between owners.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDXW     = ARB_IDXW,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    parameter int HCW      = ARB_HCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            release_i,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);
    arb_state_t      state, state_d;
    logic [IDXW-1:0] ptr, ptr_d, pick, cand, idx_d;
    logic [HCW-1:0]  hold_cnt, hold_d;
    logic [N-1:0]    grant_d;
    logic            found, done, forced, win, keep, valid_d;

    // rotating priority search starting at ptr, wrapping through the index width
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDXW'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // a normal release wins over the hold limit on the same edge
    assign done   = (state == OWN) && (release_i || !req[grant_idx]);
    assign forced = (state == OWN) && !done && (hold_cnt == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            hold_cnt    <= hold_d;
            grant       <= grant_d;
            grant_idx   <= idx_d;
            grant_valid <= valid_d;
            timeout     <= forced;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = found ? OWN : IDLE;
            OWN:     state_d = (done || forced) ? GAP : OWN;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win     = (state == IDLE) && found;
        keep    = (state == OWN) && !done && !forced;
        valid_d = win || keep;
        idx_d   = win ? pick : grant_idx;
        hold_d  = keep ? hold_cnt + 1'b1 : '0;
        ptr_d   = (done || forced) ? grant_idx + 1'b1 : ptr;
    end

    idx_to_onehot #(.IDXW(IDXW)) u_onehot (
        .idx    (idx_d),
        .en     (valid_d),
        .onehot (grant_d)
    );
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed scenarios plus random traffic against a cycle-level ownership model.
module tb_rr_grant_arbiter;
    localparam int N = 8;
    localparam int MAX_HOLD = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic         release_i = 1'b0;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         grant_valid;
    logic         timeout;

    int checks = 0;
    int fails = 0;

    // model: current owner (-1 if none), cycles owned, next search start, gap flag, timeout pulse
    int m_own, m_cnt, m_ptr, m_gap, m_to;

    rr_grant_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_ptr = 0; m_gap = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rel);
        m_to = 0;
        if (m_gap != 0) begin
            m_gap = 0;
        end else if (m_own >= 0) begin
            m_cnt++;
            if (rel || !r[m_own]) begin
                m_ptr = (m_own + 1) % N; m_own = -1; m_gap = 1;
            end else if (m_cnt == MAX_HOLD) begin
                m_ptr = (m_own + 1) % N; m_own = -1; m_gap = 1; m_to = 1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_own < 0 && r[(m_ptr + i) % N]) begin
                    m_own = (m_ptr + i) % N; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("grant_valid", grant_valid, m_own >= 0);
        chk("grant", grant, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        chk("timeout", timeout, m_to);
        if (m_own >= 0) chk("grant_idx", grant_idx, m_own);
    endtask

    task automatic tick();
        logic [N-1:0] r;
        logic rel;
        r = req; rel = release_i;
        @(posedge clk);
        if (!rst) model_edge(r, rel);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; release_i = 1'b0;
        #2;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n, gaps;
        model_reset();
        do_reset();
        chk("reset_grant", grant, 0);
        chk("reset_valid", grant_valid, 0);

        // single requester, release after 3 owned cycles, then pointer check via grant of 3 over 0
        req = 8'b0000_0100;
        tick();
        chk("single_grant", grant, 8'b0000_0100);
        chk("single_idx", grant_idx, 2);
        tick(); tick();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("single_drop", grant, 0);
        chk("single_noto", timeout, 0);
        req = 8'b0000_1001;
        tick(); tick();
        chk("ptr_after_2", grant_idx, 3);

        // rotation with release every ownership
        do_reset();
        req = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++) begin
            chk("rot_idx", grant_idx, g % N);
            chk("rot_onehot", grant, 32'd1 << (g % N));
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            gaps = 1;
            while (!grant_valid && gaps < 10) begin tick(); if (!grant_valid) gaps++; end
            chk("rot_gap", gaps, 2);
        end

        // timeout: hold for exactly MAX_HOLD cycles, pulse, re-grant
        do_reset();
        req = 8'b0001_0000;
        tick();
        n = 0;
        while (grant_valid && n < 40) begin n++; tick(); end
        chk("to_len", n, 16);
        chk("to_pulse", timeout, 1);
        tick();
        chk("to_clear", timeout, 0);
        tick();
        chk("to_regrant", grant_idx, 4);
        chk("to_regrant_v", grant_valid, 1);

        // release on the same edge as the hold limit
        for (int i = 0; i < 15; i++) tick();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("sim_drop", grant_valid, 0);
        chk("sim_noto", timeout, 0);

        // wrap: owner 5 leaves ptr=6, then 0 wins over 5
        do_reset();
        req = 8'b0010_0000;
        tick();
        release_i = 1'b1; tick(); release_i = 1'b0;
        req = 8'b0010_0001;
        tick(); tick();
        chk("wrap_idx0", grant_idx, 0);
        release_i = 1'b1; tick(); release_i = 1'b0;
        tick(); tick();
        chk("wrap_idx5", grant_idx, 5);

        // asynchronous reset mid-grant
        do_reset();
        req = 8'b1000_0000;
        tick();
        chk("mid_grant", grant, 8'b1000_0000);
        #2 rst = 1'b1;
        #1;
        chk("async_grant", grant, 0);
        chk("async_valid", grant_valid, 0);
        chk("async_to", timeout, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        req = 8'h81;
        tick();
        chk("post_rst_idx", grant_idx, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 15) == 0) req = '0;
            release_i = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
